// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NONE = 2'd0,
        BOOTH_ADD  = 2'd1,
        BOOTH_SUB  = 2'd2
    } booth_t;

    function automatic int cnt_width(input int iters);
        return $clog2(iters) + 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

    // Radix-2 Booth recoding of the pair (Q[0], q_-1).
    function automatic booth_t booth_sel(input logic q0, input logic qm1);
        booth_t sel;
        case ({q0, qm1})
            2'b01:   sel = BOOTH_ADD;
            2'b10:   sel = BOOTH_SUB;
            default: sel = BOOTH_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cla_adder32.sv
// 8-bit carry-lookahead block and the WIDTH-bit adder chained from it
// through a second-level group carry ripple.
module cla_block8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       g,
    output logic       p
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;
    logic [8:0] w_c0;

    // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    function automatic logic [8:0] lookahead(input logic [7:0] gg, input logic [7:0] pp,
                                             input logic ci);
        logic [8:0] c;
        logic       prod;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = gg[i];
            prod   = pp[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & gg[j]);
                prod   = prod & pp[j];
            end
            c[i+1] = c[i+1] | (prod & ci);
        end
        return c;
    endfunction

    always_comb begin
        w_g  = x & y;
        w_p  = x ^ y;
        w_c  = lookahead(w_g, w_p, cin);
        w_c0 = lookahead(w_g, w_p, 1'b0);
        s    = w_p ^ w_c[7:0];
        g    = w_c0[8];
        p    = &w_p;
    end
endmodule

module cla_adder32 import multdiv_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] S,
    output logic             cout
);
    localparam int NB = WIDTH / 8;

    logic [NB-1:0] w_g;
    logic [NB-1:0] w_p;
    logic [NB:0]   w_c;

    assign w_c[0] = cin;

    for (genvar b = 0; b < NB; b++) begin : g_blk
        cla_block8 u_blk (
            .x   (x[8*b +: 8]),
            .y   (y[8*b +: 8]),
            .cin (w_c[b]),
            .s   (S[8*b +: 8]),
            .g   (w_g[b]),
            .p   (w_p[b])
        );
        assign w_c[b+1] = w_g[b] | (w_p[b] & w_c[b]);
    end

    assign cout = w_c[NB];
endmodule

// File: rtl/multdiv_seq.sv
// Multicycle signed multiplier (radix-2 Booth) / divider (non-restoring on
// magnitudes) sharing one carry-lookahead adder, one add/sub per cycle.
module multdiv_seq import multdiv_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int ITERS = WIDTH;
    localparam int CW    = cnt_width(ITERS);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_hi;     // Booth accumulator (low WIDTH bits) or signed remainder
    logic [WIDTH-1:0] r_lo;     // Booth multiplier Q or dividend/quotient shift register
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;      // multiplicand or divisor magnitude
    logic             r_neg;
    logic             r_dz;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    booth_t           w_booth;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_msum;
    logic             w_msign;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mlo_nx;
    logic             w_mexc;
    logic [WIDTH:0]   w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_dres;
    logic             w_dexc;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        w_booth = booth_sel(r_lo[0], r_qm1);
        w_rs    = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
        w_x     = r_hi[WIDTH-1:0];
        w_y     = r_m;
        w_cin   = 1'b0;
        if (r_state == ST_DIV) begin
            w_x   = w_rs[WIDTH-1:0];
            w_y   = r_hi[WIDTH] ? r_m : ~r_m;
            w_cin = ~r_hi[WIDTH];
        end else if (w_booth == BOOTH_SUB) begin
            w_y   = ~r_m;
            w_cin = 1'b1;
        end
    end

    cla_adder32 #(.WIDTH(WIDTH)) u_add (
        .x    (w_x),
        .y    (w_y),
        .cin  (w_cin),
        .S    (w_sum),
        .cout (w_cout)
    );

    // The true sign of the (WIDTH+1)-bit sum is recovered from the carry so
    // that subtracting the most negative multiplicand shifts in the right bit.
    always_comb begin
        w_msum   = (w_booth == BOOTH_NONE) ? r_hi[WIDTH-1:0] : w_sum;
        w_msign  = (w_booth == BOOTH_NONE) ? r_hi[WIDTH-1]
                                           : (r_hi[WIDTH-1] ^ w_y[WIDTH-1] ^ w_cout);
        w_acc_nx = {w_msign, w_msum[WIDTH-1:1]};
        w_mlo_nx = {w_msum[0], r_lo[WIDTH-1:1]};
        w_mexc   = (w_acc_nx != {WIDTH{w_mlo_nx[WIDTH-1]}});

        w_rem_nx = {w_rs[WIDTH] ^ ~r_hi[WIDTH] ^ w_cout, w_sum};
        w_quo_nx = {r_lo[WIDTH-2:0], ~w_rem_nx[WIDTH]};
        w_dres   = r_dz ? '0 : (r_neg ? negate(w_quo_nx) : w_quo_nx);
        w_dexc   = r_dz | (~r_neg & w_quo_nx[WIDTH-1]);

        w_last   = (r_cnt == CW'(ITERS - 1));
        w_mag_a  = data_operandA[WIDTH-1] ? negate(data_operandA) : data_operandA;
        w_mag_b  = data_operandB[WIDTH-1] ? negate(data_operandB) : data_operandB;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_qm1    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            if (ctrl_MULT) begin
                r_state <= ST_MUL;
                r_lo    <= data_operandB;
                r_m     <= data_operandA;
                r_neg   <= 1'b0;
                r_dz    <= 1'b0;
            end else begin
                r_state <= ST_DIV;
                r_lo    <= w_mag_a;
                r_m     <= w_mag_b;
                r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_dz    <= (data_operandB == '0);
            end
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_hi  <= {1'b0, w_acc_nx};
                    r_lo  <= w_mlo_nx;
                    r_qm1 <= r_lo[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_result <= w_mlo_nx;
                        r_exc    <= w_mexc;
                        r_rdy    <= 1'b1;
                    end
                end
                ST_DIV: begin
                    r_hi  <= w_rem_nx;
                    r_lo  <= w_quo_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_result <= w_dres;
                        r_exc    <= w_dexc;
                        r_rdy    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b0;
                end
                default: begin
                    r_rdy <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: latency, products, quotients, abort and reset.
module tb_multdiv_seq;
    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; the following edge is the start edge.
    task automatic start_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = dv;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic watch(input int ncyc, output int lat, output int pulses,
                         output logic [31:0] res, output logic exc);
        lat    = 0;
        pulses = 0;
        res    = '0;
        exc    = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    res = data_result;
                    exc = data_exception;
                end
            end
        end
    endtask

    task automatic run_op(input string tag, input bit mul, input bit dv,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int          lat;
        int          pulses;
        logic [31:0] res;
        logic        exc;
        start_op(mul, dv, a, b);
        watch(40, lat, pulses, res, exc);
        chk({tag, "_lat"}, lat, 32);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_exc"}, {31'b0, exc}, {31'b0, exp_exc});
        chk({tag, "_hold"}, data_result, exp_res);
    endtask

    int          lat;
    int          pulses;
    int          pre_pulses;
    logic [31:0] res;
    logic        exc;

    initial begin
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_res", data_result, 32'h0);
        chk("rst_exc", {31'b0, data_exception}, 32'h0);
        chk("rst_rdy", {31'b0, data_resultRDY}, 32'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op("mul_7xm6",     1, 0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
        run_op("mul_ovf",      1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_op("mul_min_x1",   1, 0, 32'h80000000, 32'd1,        32'h80000000, 1'b0);
        run_op("div_m100_7",   0, 1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0);
        run_op("div_100_m7",   0, 1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
        run_op("div_by_zero",  0, 1, 32'd5,        32'd0,        32'h00000000, 1'b1);
        run_op("div_min_m1",   0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("both_pulses",  1, 1, 32'd6,        32'd3,        32'd18,       1'b0);

        // Abort a multiply at iteration 10 with a divide.
        start_op(1, 0, 32'd3, 32'd4);
        watch(10, lat, pre_pulses, res, exc);
        start_op(0, 1, 32'd20, 32'd4);
        watch(40, lat, pulses, res, exc);
        chk("abort_pulses", pre_pulses + pulses, 1);
        chk("abort_lat", lat, 32);
        chk("abort_res", res, 32'd5);

        // Asynchronous reset mid-multiply.
        start_op(1, 0, 32'd7, 32'd9);
        watch(15, lat, pre_pulses, res, exc);
        reset_n = 1'b0;
        #1;
        chk("midrst_res", data_result, 32'h0);
        chk("midrst_exc", {31'b0, data_exception}, 32'h0);
        chk("midrst_rdy", {31'b0, data_resultRDY}, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        watch(40, lat, pulses, res, exc);
        chk("midrst_norms", pre_pulses + pulses, 0);
        run_op("mul_2x3", 1, 0, 32'd2, 32'd3, 32'd6, 1'b0);

        // Reset clears a held nonzero result without waiting for a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_clr_res", data_result, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
